cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) among the out-of-order core's functional units.

---
 rtl/cdb_arbiter.sv | 99 +++++++++
 tb/tb_cdb_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that picks one completed functional-unit
// result per cycle and registers it onto the common data bus.
module cdb_arbiter #(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned ROB_IDX_W = 5,
  parameter  int unsigned DATA_W    = 32,
  localparam int unsigned RD_W      = 5,
  localparam int unsigned SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_REQ*RD_W-1:0]      req_rd_addr,
  input  logic [NUM_REQ-1:0]           req_regf_we,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic                         cdb_valid,
  output logic [ROB_IDX_W-1:0]         cdb_rob_idx,
  output logic [RD_W-1:0]              cdb_rd_addr,
  output logic                         cdb_regf_we,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [SRC_W-1:0]             cdb_src
);

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     ptr_next;
  logic                 gnt;
  int unsigned          scan;

  logic [ROB_IDX_W-1:0] rob_arr  [NUM_REQ];
  logic [RD_W-1:0]      rd_arr   [NUM_REQ];
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  // Split the flat per-FU payload buses into indexable arrays.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rob_arr[i]  = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      rd_arr[i]   = req_rd_addr[i*RD_W +: RD_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan from rr_ptr; first valid requester wins. Reset and
  // flush suppress the grant so nothing is consumed in those cycles.
  always_comb begin
    gnt       = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = (32'(rr_ptr) + k) % NUM_REQ;
      if (!gnt && req_valid[SRC_W'(scan)]) begin
        gnt     = 1'b1;
        gnt_idx = SRC_W'(scan);
      end
    end
    if (rst || flush) begin
      gnt = 1'b0;
    end
    if (gnt) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves one past the winner, wrapping at the last requester.
  always_comb begin
    ptr_next = rr_ptr;
    if (gnt) begin
      ptr_next = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  // Broadcast register: valid follows the grant; payload holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_rd_addr <= '0;
      cdb_regf_we <= 1'b0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else begin
      cdb_valid <= gnt;
      rr_ptr    <= ptr_next;
      if (gnt) begin
        cdb_rob_idx <= rob_arr[gnt_idx];
        cdb_rd_addr <= rd_arr[gnt_idx];
        cdb_regf_we <= req_regf_we[gnt_idx];
        cdb_data    <= data_arr[gnt_idx];
        cdb_src     <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic checked against
// a behavioural round-robin model of the common data bus arbiter.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_rob_idx;
  logic [N*5-1:0]  req_rd_addr;
  logic [N-1:0]    req_regf_we;
  logic [N*DW-1:0] req_data;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_idx;
  logic [4:0]      cdb_rd_addr;
  logic            cdb_regf_we;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
  logic [45:0]     cdb_bus;

  // Functional-unit side of the bench
  logic          fu_v   [N];
  logic [RW-1:0] fu_rob [N];
  logic [4:0]    fu_rd  [N];
  logic          fu_we  [N];
  logic [DW-1:0] fu_dat [N];

  // Reference model: pointer plus the last broadcast
  int            m_ptr;
  logic          m_valid;
  logic [RW-1:0] m_rob;
  logic [4:0]    m_rd;
  logic          m_we;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rob_idx (req_rob_idx),
    .req_rd_addr (req_rd_addr),
    .req_regf_we (req_regf_we),
    .req_data    (req_data),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_rd_addr (cdb_rd_addr),
    .cdb_regf_we (cdb_regf_we),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src)
  );

  assign cdb_bus = {cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data, cdb_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = fu_v[i];
      req_rob_idx[i*RW +: RW] = fu_rob[i];
      req_rd_addr[i*5 +: 5]   = fu_rd[i];
      req_regf_we[i]          = fu_we[i];
      req_data[i*DW +: DW]    = fu_dat[i];
    end
  end

  // Grant properties that must hold every cycle
  always @(negedge clk) begin
    n_checks++;
    if ($onehot0(req_ready) !== 1'b1) begin
      n_fail++;
      $display("FAIL onehot0_ready: req_ready=%b is not onehot0", req_ready);
    end
    n_checks++;
    if ((req_ready & ~req_valid) !== '0) begin
      n_fail++;
      $display("FAIL ready_implies_valid: req_ready=%b req_valid=%b", req_ready, req_valid);
    end
  end

  // Expected winner: first valid FU scanning from the pointer, none under rst/flush
  function automatic int exp_grant();
    if (rst || flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (fu_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ready_of(int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  function automatic logic [45:0] model_bus();
    return {m_valid, m_rob, m_rd, m_we, m_data, m_src};
  endfunction

  // Advance one clock and update the model with what was presented before the edge
  task automatic tick(output int g);
    g = exp_grant();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_rob = '0; m_rd = '0;
      m_we = 1'b0; m_data = '0; m_src = '0;
    end else begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_rob  = fu_rob[g];
        m_rd   = fu_rd[g];
        m_we   = fu_we[g];
        m_data = fu_dat[g];
        m_src  = 2'(g);
        m_ptr  = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      fu_v[i] = 1'b0; fu_rob[i] = '0; fu_rd[i] = '0; fu_we[i] = 1'b0; fu_dat[i] = '0;
    end
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    clear_inputs();
    tick(g);
    tick(g);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      fu_v[i] = 1'b1; fu_rob[i] = 5'($urandom); fu_rd[i] = 5'($urandom);
      fu_we[i] = 1'b1; fu_dat[i] = $urandom;
    end
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    tick(g);
    n_checks++;
    if (cdb_bus !== 46'd0) begin
      n_fail++; $display("FAIL reset_cdb: got %h expected 0", cdb_bus);
    end
    n_checks++;
    if (dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr);
    end
    tick(g);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single();
    int g;
    fu_v[0] = 1'b1; fu_rob[0] = 5'd3; fu_rd[0] = 5'd5; fu_we[0] = 1'b1; fu_dat[0] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    tick(g);
    fu_v[0] = 1'b0;
    #1;
    n_checks++;
    if (cdb_bus !== {1'b1, 5'd3, 5'd5, 1'b1, 32'hDEADBEEF, 2'd0}) begin
      n_fail++; $display("FAIL single_cdb: got %h expected %h", cdb_bus,
                         {1'b1, 5'd3, 5'd5, 1'b1, 32'hDEADBEEF, 2'd0});
    end
    tick(g);
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_drop: valid=%b data=%h expected valid=0 data held", cdb_valid, cdb_data);
    end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      fu_v[i] = 1'b1; fu_rob[i] = 5'(10 + i); fu_rd[i] = 5'(i); fu_we[i] = 1'b1; fu_dat[i] = $urandom;
    end
    for (int c = 0; c < N; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << c)) begin
        n_fail++; $display("FAIL rr_ready_%0d: got %b expected %b", c, req_ready, 4'(1 << c));
      end
      tick(g);
      fu_v[c] = 1'b0;
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(c) || cdb_rob_idx !== 5'(10 + c)) begin
        n_fail++; $display("FAIL rr_cdb_%0d: valid=%b src=%0d rob=%0d expected 1/%0d/%0d",
                           c, cdb_valid, cdb_src, cdb_rob_idx, c, 10 + c);
      end
    end
    n_checks++;
    if (dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL rr_wrap_ptr: got %0d expected 0", dut.rr_ptr);
    end
    tick(g);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle: cdb_valid=%b expected 0", cdb_valid);
    end
  endtask

  task automatic test_pair();
    int g;
    int seq [4] = '{3, 1, 3, 1};
    fu_v[1] = 1'b1; fu_rob[1] = 5'd21; fu_dat[1] = 32'h1111;
    #1;
    tick(g);
    fu_v[3] = 1'b1; fu_rob[3] = 5'd23; fu_dat[3] = 32'h3333;
    #1;
    n_checks++;
    if (dut.rr_ptr !== 2'd2) begin
      n_fail++; $display("FAIL pair_ptr: got %0d expected 2", dut.rr_ptr);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (req_ready !== 4'(1 << seq[c])) begin
        n_fail++; $display("FAIL pair_ready_%0d: got %b expected %b", c, req_ready, 4'(1 << seq[c]));
      end
      tick(g);
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(seq[c])) begin
        n_fail++; $display("FAIL pair_src_%0d: valid=%b src=%0d expected 1/%0d", c, cdb_valid, cdb_src, seq[c]);
      end
    end
    clear_inputs();
    tick(g);
  endtask

  task automatic test_flush();
    int g;
    fu_v[2] = 1'b1; fu_rob[2] = 5'd7; fu_rd[2] = 5'd9; fu_dat[2] = 32'hCAFE0002;
    flush = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL flush_ready: got %b expected 0000", req_ready);
    end
    tick(g);
    flush = 1'b0;
    #1;
    n_checks++;
    if (cdb_valid !== 1'b0 || dut.rr_ptr !== 2'd2) begin
      n_fail++; $display("FAIL flush_hold: valid=%b ptr=%0d expected 0/2", cdb_valid, dut.rr_ptr);
    end
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL flush_regrant: got %b expected 0100", req_ready);
    end
    tick(g);
    fu_v[2] = 1'b0;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_data !== 32'hCAFE0002) begin
      n_fail++; $display("FAIL flush_cdb: valid=%b src=%0d data=%h expected 1/2/cafe0002", cdb_valid, cdb_src, cdb_data);
    end
  endtask

  task automatic test_flush_after_grant();
    int g;
    fu_v[1] = 1'b1; fu_rob[1] = 5'd17; fu_dat[1] = 32'h0BAD0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL fag_ready: got %b expected 0010", req_ready);
    end
    tick(g);
    fu_v[1] = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL fag_complete: valid=%b src=%0d ready=%b expected 1/1/0000", cdb_valid, cdb_src, req_ready);
    end
    tick(g);
    flush = 1'b0;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL fag_killed: cdb_valid=%b expected 0", cdb_valid);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    fu_v[2] = 1'b1; fu_rob[2] = 5'd30; fu_dat[2] = 32'h5555AAAA; fu_we[2] = 1'b1;
    #1;
    tick(g);
    fu_v[2] = 1'b0;
    n_checks++;
    if (cdb_valid !== 1'b1 || dut.rr_ptr !== 2'd3) begin
      n_fail++; $display("FAIL rmid_pre: valid=%b ptr=%0d expected 1/3", cdb_valid, dut.rr_ptr);
    end
    rst = 1'b1; flush = 1'b1;
    fu_v[1] = 1'b1; fu_rob[1] = 5'd11;
    fu_v[3] = 1'b1; fu_rob[3] = 5'd13;
    #1;
    tick(g);
    n_checks++;
    if (cdb_bus !== 46'd0 || dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL rmid_state: cdb=%h ptr=%0d expected 0/0", cdb_bus, dut.rr_ptr);
    end
    rst = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rmid_first: got %b expected 0010", req_ready);
    end
    tick(g);
    clear_inputs();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_rob_idx !== 5'd11) begin
      n_fail++; $display("FAIL rmid_cdb: valid=%b src=%0d rob=%0d expected 1/1/11", cdb_valid, cdb_src, cdb_rob_idx);
    end
  endtask

  task automatic test_random();
    int  last_g;
    bit  last_flush;
    do_reset();
    last_g = -1;
    last_flush = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (last_flush) begin
          fu_v[i] = 1'b0;
        end else if (last_g == i || !fu_v[i]) begin
          fu_v[i] = (last_g == i) ? 1'($urandom % 2) : ($urandom % 5 < 2);
          if (fu_v[i]) begin
            fu_rob[i] = 5'($urandom); fu_rd[i] = 5'($urandom);
            fu_we[i]  = 1'($urandom); fu_dat[i] = $urandom;
          end
        end
      end
      flush = ($urandom % 12 == 0);
      rst   = ($urandom % 60 == 0);
      #1;
      n_checks++;
      if (req_ready !== ready_of(exp_grant())) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, req_ready, ready_of(exp_grant()));
      end
      n_checks++;
      if (cdb_bus !== model_bus()) begin
        n_fail++; $display("FAIL rand_cdb cyc %0d: got %h expected %h", cyc, cdb_bus, model_bus());
      end
      last_flush = flush;
      tick(last_g);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    int g;
    rst = 1'b1;
    clear_inputs();
    m_ptr = 0; m_valid = 1'b0; m_rob = '0; m_rd = '0; m_we = 1'b0; m_data = '0; m_src = '0;
    tick(g);
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_flush();
    test_flush_after_grant();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
